// File: rtl/sd_req_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : sd_req_arbiter_if
// Purpose  : Requester-side and mist_io-side signals of the SD block-port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sd_req_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ*32-1:0] req_lba;
   logic [NREQ-1:0]    req_rd;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ-1:0]    req_ack;
   logic [NREQ-1:0]    req_done;
   logic [NREQ-1:0]    req_err;
   logic [NREQ-1:0]    req_buff_wr;
   logic [NREQ*8-1:0]  req_buff_din;
   logic [31:0]        sd_lba;
   logic               sd_rd;
   logic               sd_wr;
   logic               sd_ack;
   logic               sd_buff_wr;
   logic [7:0]         sd_buff_din;
   logic               busy;
   logic [1:0]         grant;

   // master: the arbiter itself; slave: requesters plus mist_io
   modport master (
      input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
      output req_ack, req_done, req_err, req_buff_wr,
             sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant
   );

   modport slave (
      output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
      input  req_ack, req_done, req_err, req_buff_wr,
             sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant
   );
endinterface

`default_nettype wire

// File: rtl/sd_req_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sd_req_arbiter
// Purpose  : Round-robin sharing of the mist_io SD sector port among NREQ requesters.
//            Optional ISSUE timeout enabled by macro SD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sd_req_arbiter #(
   parameter int          NREQ    = 2,
   parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
   input  wire logic        clk_sys,
   input  wire logic        reset_n,
   sd_req_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_XFER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [1:0]        grant_q;
   logic [1:0]        last_q;
   logic [31:0]       sd_lba_q;
   logic              sd_rd_q;
   logic              sd_wr_q;
   logic [NREQ-1:0]   req_ack_q;
   logic [NREQ-1:0]   req_done_q;
   logic              ack_meta_q;
   logic              ack_s_q;
   logic              ack_prev_q;

   logic [31:0]       w_lba [4];
   logic [7:0]        w_din [4];
   logic [3:0]        w_rd4;
   logic [3:0]        w_wr4;
   logic [3:0]        w_pend4;
   logic [3:0]        w_gnt_oh;
   logic [1:0]        w_pick;
   logic [1:0]        w_idx;
   logic              w_found;
   logic              w_ack_rise;
   logic              w_ack_fall;

   // Pad per-requester slices to four entries so a 2-bit index is always in range
   for (genvar i = 0; i < 4; i++) begin : g_slot
      if (i < NREQ) begin : g_live
         assign w_lba[i] = bus.req_lba[32*i +: 32];
         assign w_din[i] = bus.req_buff_din[8*i +: 8];
      end else begin : g_pad
         assign w_lba[i] = '0;
         assign w_din[i] = '0;
      end
   end

   assign w_rd4      = 4'(bus.req_rd);
   assign w_wr4      = 4'(bus.req_wr);
   assign w_pend4    = w_rd4 | w_wr4;
   assign w_gnt_oh   = 4'b0001 << grant_q;
   assign w_ack_rise = ack_s_q & ~ack_prev_q;
   assign w_ack_fall = ~ack_s_q & ack_prev_q;

   always_comb begin
      w_pick  = last_q;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = 2'((int'(last_q) + k) % NREQ);
         if (!w_found && w_pend4[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   logic [23:0]     tmo_q;
   logic [NREQ-1:0] req_err_q;
   assign bus.req_err = req_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign bus.req_err    = '0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         last_q     <= 2'(NREQ - 1);
         sd_lba_q   <= '0;
         sd_rd_q    <= 1'b0;
         sd_wr_q    <= 1'b0;
         req_ack_q  <= '0;
         req_done_q <= '0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
         ack_prev_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
         tmo_q      <= '0;
         req_err_q  <= '0;
`endif
      end else begin
         ack_meta_q <= bus.sd_ack;
         ack_s_q    <= ack_meta_q;
         ack_prev_q <= ack_s_q;
         req_done_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
         req_err_q  <= '0;
         if (state_q == S_ISSUE) begin
            tmo_q <= tmo_q + 24'd1;
         end
`endif
         case (state_q)
            S_IDLE: begin
               if (w_found) begin
                  sd_lba_q <= w_lba[w_pick];
                  sd_rd_q  <= w_rd4[w_pick];
                  sd_wr_q  <= ~w_rd4[w_pick];
                  grant_q  <= w_pick;
                  state_q  <= S_ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                  tmo_q    <= '0;
`endif
               end
            end
            S_ISSUE: begin
               if (w_ack_rise) begin
                  sd_rd_q   <= 1'b0;
                  sd_wr_q   <= 1'b0;
                  req_ack_q <= NREQ'(w_gnt_oh);
                  state_q   <= S_XFER;
               end else if (!w_rd4[grant_q] && !w_wr4[grant_q]) begin
                  // Withdrawal: no completion and the round-robin pointer stays put
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  state_q <= S_IDLE;
               end
`ifdef SD_ARB_TIMEOUT_EN
               else if (tmo_q == TIMEOUT - 24'd1) begin
                  sd_rd_q    <= 1'b0;
                  sd_wr_q    <= 1'b0;
                  req_done_q <= NREQ'(w_gnt_oh);
                  req_err_q  <= NREQ'(w_gnt_oh);
                  state_q    <= S_DONE;
               end
`endif
            end
            S_XFER: begin
               if (w_ack_fall) begin
                  req_ack_q  <= '0;
                  req_done_q <= NREQ'(w_gnt_oh);
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               last_q  <= grant_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.sd_lba      = sd_lba_q;
   assign bus.sd_rd       = sd_rd_q;
   assign bus.sd_wr       = sd_wr_q;
   assign bus.req_ack     = req_ack_q;
   assign bus.req_done    = req_done_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.grant       = grant_q;
   assign bus.sd_buff_din = w_din[grant_q];
   assign bus.req_buff_wr = ((state_q == S_XFER) && bus.sd_buff_wr) ? NREQ'(w_gnt_oh) : '0;

endmodule

`default_nettype wire
